alarm_match_ctrl: RTL and testbench

Multi-channel alarm comparator and ringer controller, fed by the RTC time-of-day fields (hours, minutes, seconds; BCD, one byte each) and the user-programmed alarm setpoints from the display/config path. Each channel detects the first cycle its setpoint equals the current time and then rings. Ringing ends on acknowledge or on timeout, and each channel supports snooze. Outputs drive the buzzer/LED logic and the on-screen alarm indicator.

---
 rtl/alarm_pkg.sv | 32 +++
 rtl/alarm_channel.sv | 138 +++++++++++++
 rtl/alarm_match_ctrl.sv | 73 +++++++
 tb/tb_alarm_match_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// ============================================================================
// Module      : alarm_pkg
// Description : Shared types and constants for the alarm comparator/ringer:
//               channel state encoding, default time-field width and the
//               helpers used to slice packed setpoints.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

    // Per-channel ringer state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    // Default width of one BCD time field
    localparam int FIELD_W_DEF = 8;

    // Each setpoint packs {hours, minutes, seconds}
    localparam int NUM_FIELDS = 3;

    // LSB position of channel ch's setpoint inside the packed setpoint bus
    function automatic int setpoint_lsb(input int ch, input int fw);
        return ch * NUM_FIELDS * fw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_channel.sv
// ============================================================================
// Module      : alarm_channel
// Description : One alarm channel: setpoint comparator, match edge detector,
//               IDLE/RINGING/SNOOZE state machine, per-second counter and the
//               optional sticky missed-alarm flag.
//               Optional feature macro: ALARM_MISSED_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_channel
    import alarm_pkg::*;
#(
    parameter int FIELD_W     = FIELD_W_DEF,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FIELD_W-1:0]            time_h,
    input  logic [FIELD_W-1:0]            time_m,
    input  logic [FIELD_W-1:0]            time_s,
    input  logic                          sec_tick,
    input  logic [NUM_FIELDS*FIELD_W-1:0] setpoint,
    input  logic                          enable,
    input  logic                          ack,
    input  logic                          snooze,
    output logic                          ringing,
    output logic                          missed
);

    localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CNT_W    = (MAX_SECS > 2) ? $clog2(MAX_SECS) : 1;

    localparam logic [CNT_W-1:0] c_ring_last   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] c_snooze_last = CNT_W'(SNOOZE_SECS - 1);

    alarm_state_t     r_state;
    alarm_state_t     w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_match_q;
    logic             w_match;
    logic             w_trigger;
    logic             w_timeout;
    logic             w_expiry;

    // An all-zero setpoint is unprogrammed and never matches
    assign w_match   = enable
                     && ({time_h, time_m, time_s} == setpoint)
                     && (setpoint != '0);
    assign w_trigger = w_match && !r_match_q;

    // Timeout only counts when nothing of higher priority acts this cycle,
    // so a simultaneous ack or snooze is not reported as a missed alarm
    assign w_timeout = enable && (r_state == RINGING) && !ack && !snooze
                     && sec_tick && (r_cnt == c_ring_last);
    assign w_expiry  = (r_state == SNOOZE) && sec_tick && (r_cnt == c_snooze_last);

    // Match history for rising-edge trigger detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic in priority order: disable > ack > snooze > timers > trigger
    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) w_next = RINGING;
                end
                RINGING: begin
                    if (ack)            w_next = IDLE;
                    else if (snooze)    w_next = SNOOZE;
                    else if (w_timeout) w_next = IDLE;
                end
                SNOOZE: begin
                    if (ack)           w_next = IDLE;
                    else if (w_expiry) w_next = RINGING;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Second counter: restarts on every state change, saturates rather than wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((w_next != r_state) || (r_state == IDLE)) begin
            r_cnt <= '0;
        end else if (sec_tick && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Ringing flag decoded straight from the state register
    always_comb begin
        ringing = (r_state == RINGING);
    end

`ifdef ALARM_MISSED_EN
    logic r_missed;

    // Sticky flag for a ring that ended unanswered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_missed <= 1'b0;
        end else if (ack) begin
            r_missed <= 1'b0;
        end else if (w_timeout) begin
            r_missed <= 1'b1;
        end
    end

    assign missed = r_missed;
`else
    assign missed = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/alarm_match_ctrl.sv
// ============================================================================
// Module      : alarm_match_ctrl
// Description : Multi-channel alarm comparator and ringer controller. Unpacks
//               the setpoint bus into per-channel comparators/FSMs and
//               produces the any-ringing flag and lowest ringing index.
//               Optional feature macro: ALARM_MISSED_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_match_ctrl
    import alarm_pkg::*;
#(
    parameter int N_ALARMS    = 4,
    parameter int FIELD_W     = FIELD_W_DEF,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [FIELD_W-1:0]                       time_h,
    input  logic [FIELD_W-1:0]                       time_m,
    input  logic [FIELD_W-1:0]                       time_s,
    input  logic                                     sec_tick,
    input  logic [N_ALARMS*NUM_FIELDS*FIELD_W-1:0]   alarm_set,
    input  logic [N_ALARMS-1:0]                      alarm_en,
    input  logic                                     ack,
    input  logic                                     snooze,
    output logic [N_ALARMS-1:0]                      ringing,
    output logic                                     alarm_any,
    output logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] active_idx,
    output logic [N_ALARMS-1:0]                      missed
);

    localparam int IDX_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int SET_W = NUM_FIELDS * FIELD_W;

    generate
        for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
            alarm_channel #(
                .FIELD_W     (FIELD_W),
                .RING_SECS   (RING_SECS),
                .SNOOZE_SECS (SNOOZE_SECS)
            ) u_channel (
                .clk      (clk),
                .reset    (reset),
                .time_h   (time_h),
                .time_m   (time_m),
                .time_s   (time_s),
                .sec_tick (sec_tick),
                .setpoint (alarm_set[setpoint_lsb(i, FIELD_W) +: SET_W]),
                .enable   (alarm_en[i]),
                .ack      (ack),
                .snooze   (snooze),
                .ringing  (ringing[i]),
                .missed   (missed[i])
            );
        end
    endgenerate

    assign alarm_any = |ringing;

    // Priority encoder: scanning downward leaves the lowest ringing index
    always_comb begin
        active_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (ringing[i]) active_idx = IDX_W'(i);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alarm_match_ctrl.sv
// ============================================================================
// Module      : tb_alarm_match_ctrl
// Description : Self-checking bench for alarm_match_ctrl. Each scenario task
//               builds a stimulus list, pushes the expected outputs into a
//               scoreboard as each step is driven and compares after the edge.
//               Optional feature macro: ALARM_MISSED_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_match_ctrl;

`ifdef ALARM_MISSED_EN
    localparam logic MISS_ON = 1'b1;
`else
    localparam logic MISS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  time_h, time_m, time_s;
    logic        sec_tick;
    logic [95:0] alarm_set;
    logic [3:0]  alarm_en;
    logic        ack, snooze;
    logic [3:0]  ringing;
    logic        alarm_any;
    logic [1:0]  active_idx;
    logic [3:0]  missed;

    typedef struct {
        logic [23:0] t;
        logic [3:0]  en;
        logic        ack, snz, tk, rst;
        logic [3:0]  ring, miss;
    } stim_t;

    typedef struct {
        logic [3:0] ring;
        logic [3:0] miss;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alarm_match_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .time_h     (time_h),
        .time_m     (time_m),
        .time_s     (time_s),
        .sec_tick   (sec_tick),
        .alarm_set  (alarm_set),
        .alarm_en   (alarm_en),
        .ack        (ack),
        .snooze     (snooze),
        .ringing    (ringing),
        .alarm_any  (alarm_any),
        .active_idx (active_idx),
        .missed     (missed)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic [23:0] t, input logic [3:0] en,
                                 input logic a, input logic s, input logic tk,
                                 input logic r, input logic [3:0] ring,
                                 input logic [3:0] miss);
        stim_t x;
        x.t = t; x.en = en; x.ack = a; x.snz = s; x.tk = tk; x.rst = r;
        x.ring = ring; x.miss = miss;
        return x;
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    // Drive one step's inputs and record what the DUT must show after the edge
    task automatic apply(input stim_t s);
        exp_t e;
        {time_h, time_m, time_s} = s.t;
        alarm_en = s.en;
        ack      = s.ack;
        snooze   = s.snz;
        sec_tick = s.tk;
        reset    = s.rst;
        e.ring   = s.ring;
        e.miss   = MISS_ON ? s.miss : 4'b0000;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  e;
        alarm_set = '0;
        st.push_back(mk(24'h000000, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0));
        st.push_back(mk(24'h000000, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0));
        st.push_back(mk(24'h000000, 4'h0, 0, 0, 1, 0, 4'h0, 4'h0));
        foreach (st[k]) begin
            apply(st[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (ringing !== e.ring) begin errors++; $display("FAIL reset[%0d] ringing got %b expected %b", k, ringing, e.ring); end
            checks++;
            if (alarm_any !== (|e.ring)) begin errors++; $display("FAIL reset[%0d] alarm_any got %b expected %b", k, alarm_any, |e.ring); end
            checks++;
            if (active_idx !== low_idx(e.ring)) begin errors++; $display("FAIL reset[%0d] active_idx got %0d expected %0d", k, active_idx, low_idx(e.ring)); end
            checks++;
            if (missed !== e.miss) begin errors++; $display("FAIL reset[%0d] missed got %b expected %b", k, missed, e.miss); end
        end
    endtask

    task automatic test_basic();
        stim_t st[$];
        exp_t  e;
        alarm_set[0 +: 24] = 24'h073000;
        st.push_back(mk(24'h072959, 4'h1, 0, 0, 1, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h073000, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0));
        st.push_back(mk(24'h073000, 4'h1, 0, 0, 1, 0, 4'h1, 4'h0));
        st.push_back(mk(24'h073000, 4'h1, 1, 0, 0, 0, 4'h0, 4'h0));
        for (int k = 0; k < 5; k++)
            st.push_back(mk(24'h073000, 4'h1, 0, 0, k[0], 0, 4'h0, 4'h0));
        foreach (st[k]) begin
            apply(st[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (ringing !== e.ring) begin errors++; $display("FAIL basic[%0d] ringing got %b expected %b", k, ringing, e.ring); end
            checks++;
            if (alarm_any !== (|e.ring)) begin errors++; $display("FAIL basic[%0d] alarm_any got %b expected %b", k, alarm_any, |e.ring); end
            checks++;
            if (active_idx !== low_idx(e.ring)) begin errors++; $display("FAIL basic[%0d] active_idx got %0d expected %0d", k, active_idx, low_idx(e.ring)); end
            checks++;
            if (missed !== e.miss) begin errors++; $display("FAIL basic[%0d] missed got %b expected %b", k, missed, e.miss); end
        end
    endtask

    task automatic test_timeout();
        stim_t st[$];
        exp_t  e;
        alarm_set[48 +: 24] = 24'h080000;
        st.push_back(mk(24'h075959, 4'h4, 0, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h080000, 4'h4, 0, 0, 0, 0, 4'h4, 4'h0));
        for (int k = 0; k < 3; k++)
            st.push_back(mk(24'h080000, 4'h4, 0, 0, 0, 0, 4'h4, 4'h0));
        for (int k = 1; k < 60; k++)
            st.push_back(mk(24'h080000, 4'h4, 0, 0, 1, 0, 4'h4, 4'h0));
        st.push_back(mk(24'h080000, 4'h4, 0, 0, 1, 0, 4'h0, 4'h4));
        st.push_back(mk(24'h080000, 4'h4, 0, 0, 1, 0, 4'h0, 4'h4));
        st.push_back(mk(24'h080000, 4'h4, 0, 0, 0, 0, 4'h0, 4'h4));
        st.push_back(mk(24'h080000, 4'h4, 1, 0, 0, 0, 4'h0, 4'h0));
        // Retrigger, then let the timeout tick coincide with ack
        st.push_back(mk(24'h080001, 4'h4, 0, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h080000, 4'h4, 0, 0, 0, 0, 4'h4, 4'h0));
        for (int k = 1; k < 60; k++)
            st.push_back(mk(24'h080000, 4'h4, 0, 0, 1, 0, 4'h4, 4'h0));
        st.push_back(mk(24'h080000, 4'h4, 1, 0, 1, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h080000, 4'h4, 0, 0, 0, 0, 4'h0, 4'h0));
        foreach (st[k]) begin
            apply(st[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (ringing !== e.ring) begin errors++; $display("FAIL timeout[%0d] ringing got %b expected %b", k, ringing, e.ring); end
            checks++;
            if (alarm_any !== (|e.ring)) begin errors++; $display("FAIL timeout[%0d] alarm_any got %b expected %b", k, alarm_any, |e.ring); end
            checks++;
            if (active_idx !== low_idx(e.ring)) begin errors++; $display("FAIL timeout[%0d] active_idx got %0d expected %0d", k, active_idx, low_idx(e.ring)); end
            checks++;
            if (missed !== e.miss) begin errors++; $display("FAIL timeout[%0d] missed got %b expected %b", k, missed, e.miss); end
        end
    endtask

    task automatic test_snooze();
        stim_t st[$];
        exp_t  e;
        alarm_set[24 +: 24] = 24'h091500;
        st.push_back(mk(24'h091459, 4'h2, 0, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h091500, 4'h2, 0, 0, 0, 0, 4'h2, 4'h0));
        st.push_back(mk(24'h091500, 4'h2, 0, 1, 0, 0, 4'h0, 4'h0));
        // A second snooze pulse mid-snooze must not restart the count
        for (int k = 1; k < 300; k++)
            st.push_back(mk(24'h091500, 4'h2, 0, (k == 150), 1, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h091500, 4'h2, 0, 0, 1, 0, 4'h2, 4'h0));
        st.push_back(mk(24'h091500, 4'h2, 0, 0, 0, 0, 4'h2, 4'h0));
        st.push_back(mk(24'h091500, 4'h2, 0, 1, 0, 0, 4'h0, 4'h0));
        for (int k = 0; k < 5; k++)
            st.push_back(mk(24'h091500, 4'h2, 0, 0, 1, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h091500, 4'h2, 1, 0, 0, 0, 4'h0, 4'h0));
        for (int k = 0; k < 310; k++)
            st.push_back(mk(24'h091500, 4'h2, 0, 0, 1, 0, 4'h0, 4'h0));
        foreach (st[k]) begin
            apply(st[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (ringing !== e.ring) begin errors++; $display("FAIL snooze[%0d] ringing got %b expected %b", k, ringing, e.ring); end
            checks++;
            if (alarm_any !== (|e.ring)) begin errors++; $display("FAIL snooze[%0d] alarm_any got %b expected %b", k, alarm_any, |e.ring); end
            checks++;
            if (active_idx !== low_idx(e.ring)) begin errors++; $display("FAIL snooze[%0d] active_idx got %0d expected %0d", k, active_idx, low_idx(e.ring)); end
            checks++;
            if (missed !== e.miss) begin errors++; $display("FAIL snooze[%0d] missed got %b expected %b", k, missed, e.miss); end
        end
    endtask

    task automatic test_shared();
        stim_t st[$];
        exp_t  e;
        alarm_set[24 +: 24] = 24'h120000;
        alarm_set[72 +: 24] = 24'h120000;
        st.push_back(mk(24'h115959, 4'hA, 0, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h120000, 4'hA, 0, 0, 0, 0, 4'hA, 4'h0));
        st.push_back(mk(24'h120000, 4'hA, 0, 0, 1, 0, 4'hA, 4'h0));
        st.push_back(mk(24'h120000, 4'hA, 1, 1, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h120000, 4'hA, 0, 0, 1, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h120000, 4'hA, 0, 0, 0, 0, 4'h0, 4'h0));
        foreach (st[k]) begin
            apply(st[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (ringing !== e.ring) begin errors++; $display("FAIL shared[%0d] ringing got %b expected %b", k, ringing, e.ring); end
            checks++;
            if (alarm_any !== (|e.ring)) begin errors++; $display("FAIL shared[%0d] alarm_any got %b expected %b", k, alarm_any, |e.ring); end
            checks++;
            if (active_idx !== low_idx(e.ring)) begin errors++; $display("FAIL shared[%0d] active_idx got %0d expected %0d", k, active_idx, low_idx(e.ring)); end
            checks++;
            if (missed !== e.miss) begin errors++; $display("FAIL shared[%0d] missed got %b expected %b", k, missed, e.miss); end
        end
    endtask

    task automatic test_zero_disable();
        stim_t st[$];
        exp_t  e;
        alarm_set[0 +: 24]  = 24'h000000;
        alarm_set[72 +: 24] = 24'h130000;
        st.push_back(mk(24'h000000, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h000000, 4'h1, 0, 0, 1, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h130000, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h130000, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h130000, 4'h9, 0, 0, 0, 0, 4'h8, 4'h0));
        st.push_back(mk(24'h130000, 4'h9, 0, 0, 1, 0, 4'h8, 4'h0));
        st.push_back(mk(24'h130000, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h130000, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0));
        foreach (st[k]) begin
            apply(st[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (ringing !== e.ring) begin errors++; $display("FAIL zero_dis[%0d] ringing got %b expected %b", k, ringing, e.ring); end
            checks++;
            if (alarm_any !== (|e.ring)) begin errors++; $display("FAIL zero_dis[%0d] alarm_any got %b expected %b", k, alarm_any, |e.ring); end
            checks++;
            if (active_idx !== low_idx(e.ring)) begin errors++; $display("FAIL zero_dis[%0d] active_idx got %0d expected %0d", k, active_idx, low_idx(e.ring)); end
            checks++;
            if (missed !== e.miss) begin errors++; $display("FAIL zero_dis[%0d] missed got %b expected %b", k, missed, e.miss); end
        end
    endtask

    task automatic test_reset_mid_ring();
        stim_t st[$];
        exp_t  e;
        alarm_set[0 +: 24] = 24'h140000;
        st.push_back(mk(24'h135959, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h140000, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0));
        st.push_back(mk(24'h140000, 4'h1, 0, 0, 0, 1, 4'h0, 4'h0));
        st.push_back(mk(24'h140000, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0));
        st.push_back(mk(24'h140000, 4'h1, 1, 0, 0, 0, 4'h0, 4'h0));
        st.push_back(mk(24'h140000, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0));
        foreach (st[k]) begin
            apply(st[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (ringing !== e.ring) begin errors++; $display("FAIL rst_mid[%0d] ringing got %b expected %b", k, ringing, e.ring); end
            checks++;
            if (alarm_any !== (|e.ring)) begin errors++; $display("FAIL rst_mid[%0d] alarm_any got %b expected %b", k, alarm_any, |e.ring); end
            checks++;
            if (active_idx !== low_idx(e.ring)) begin errors++; $display("FAIL rst_mid[%0d] active_idx got %0d expected %0d", k, active_idx, low_idx(e.ring)); end
            checks++;
            if (missed !== e.miss) begin errors++; $display("FAIL rst_mid[%0d] missed got %b expected %b", k, missed, e.miss); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        time_h    = '0;
        time_m    = '0;
        time_s    = '0;
        sec_tick  = 1'b0;
        alarm_set = '0;
        alarm_en  = '0;
        ack       = 1'b0;
        snooze    = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_timeout();
        test_snooze();
        test_shared();
        test_zero_disable();
        test_reset_mid_ring();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
